// File: rtl/dispensador_cambio.sv
// Change-note payout controller: runs the dispenser motor once per note and confirms each note at the exit sensor.
// Optional build macro CAMBIO_REINTENTO_EN allows one extra motor attempt per note before declaring a jam.
module dispensador_cambio #(
  parameter int MOTOR_CICLOS = 4,
  parameter int TIMEOUT      = 16,
  parameter int PAUSA_CICLOS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inicio,
  input  logic [2:0] vuelto,
  input  logic       sensor_billete,
  output logic       motor,
  output logic       ocupado,
  output logic       listo,
  output logic       falla,
  output logic [2:0] entregados
);

  localparam int MAX_MP = (MOTOR_CICLOS > PAUSA_CICLOS) ? MOTOR_CICLOS : PAUSA_CICLOS;
  localparam int MAX_C  = (MAX_MP > TIMEOUT) ? MAX_MP : TIMEOUT;
  localparam int CW     = (MAX_C > 1) ? $clog2(MAX_C) : 1;

  localparam logic [CW-1:0] MOTOR_FIN   = CW'(MOTOR_CICLOS - 1);
  localparam logic [CW-1:0] TIMEOUT_FIN = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] PAUSA_FIN   = CW'(PAUSA_CICLOS - 1);

  typedef enum logic [2:0] {
    REPOSO = 3'd0,
    MOTOR  = 3'd1,
    ESPERA = 3'd2,
    PAUSA  = 3'd3,
    FIN    = 3'd4,
    FALLA  = 3'd5
  } estado_t;

  estado_t       estado_q, estado_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    pendiente_q, pendiente_d;
  logic [2:0]    entregados_q, entregados_d;
  logic          visto_q, visto_d;
  logic          sens_q, sens_prev_q;
  logic          motor_q, motor_d;
  logic          ocupado_q, ocupado_d;
  logic          listo_q, listo_d;
  logic          falla_q, falla_d;
  logic          flanco_s;
  logic          en_intento_s;

`ifdef CAMBIO_REINTENTO_EN
  logic          reintento_q, reintento_d;
`endif

  assign flanco_s     = sens_q & ~sens_prev_q;
  assign en_intento_s = (estado_q == MOTOR) || (estado_q == ESPERA);

  // Registered exit sensor and its previous sample for rising-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sens_q      <= 1'b0;
      sens_prev_q <= 1'b0;
    end else begin
      sens_q      <= sensor_billete;
      sens_prev_q <= sens_q;
    end
  end

  // State, timer, note counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q     <= REPOSO;
      cnt_q        <= '0;
      pendiente_q  <= 3'd0;
      entregados_q <= 3'd0;
      visto_q      <= 1'b0;
      motor_q      <= 1'b0;
      ocupado_q    <= 1'b0;
      listo_q      <= 1'b0;
      falla_q      <= 1'b0;
    end else begin
      estado_q     <= estado_d;
      cnt_q        <= cnt_d;
      pendiente_q  <= pendiente_d;
      entregados_q <= entregados_d;
      visto_q      <= visto_d;
      motor_q      <= motor_d;
      ocupado_q    <= ocupado_d;
      listo_q      <= listo_d;
      falla_q      <= falla_d;
    end
  end

`ifdef CAMBIO_REINTENTO_EN
  // Marks that the current note has already used its single retry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reintento_q <= 1'b0;
    end else begin
      reintento_q <= reintento_d;
    end
  end
`endif

  // Next-state logic; outputs are decoded from the next state so they change on the same edge.
  always_comb begin
    estado_d     = estado_q;
    cnt_d        = cnt_q;
    pendiente_d  = pendiente_q;
    entregados_d = entregados_q;
    visto_d      = visto_q | (flanco_s & en_intento_s);
`ifdef CAMBIO_REINTENTO_EN
    reintento_d  = reintento_q;
`endif

    case (estado_q)
      REPOSO, FALLA: begin
        if (inicio && (vuelto != 3'd0)) begin
          pendiente_d  = vuelto;
          entregados_d = 3'd0;
          cnt_d        = '0;
          visto_d      = 1'b0;
`ifdef CAMBIO_REINTENTO_EN
          reintento_d  = 1'b0;
`endif
          estado_d     = MOTOR;
        end else if (inicio && (estado_q == REPOSO)) begin
          entregados_d = 3'd0;
          estado_d     = FIN;
        end else begin
          estado_d     = estado_q;
        end
      end

      MOTOR: begin
        if (cnt_q == MOTOR_FIN) begin
          cnt_d    = '0;
          estado_d = ESPERA;
        end else begin
          cnt_d    = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      ESPERA: begin
        if (visto_q || flanco_s) begin
          pendiente_d  = pendiente_q - 3'd1;
          entregados_d = entregados_q + 3'd1;
          visto_d      = 1'b0;
          cnt_d        = '0;
`ifdef CAMBIO_REINTENTO_EN
          reintento_d  = 1'b0;
`endif
          estado_d     = PAUSA;
        end else if (cnt_q == TIMEOUT_FIN) begin
          cnt_d   = '0;
          visto_d = 1'b0;
`ifdef CAMBIO_REINTENTO_EN
          if (!reintento_q) begin
            reintento_d = 1'b1;
            estado_d    = PAUSA;
          end else begin
            estado_d    = FALLA;
          end
`else
          estado_d = FALLA;
`endif
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      PAUSA: begin
        visto_d = 1'b0;
        if (cnt_q == PAUSA_FIN) begin
          cnt_d = '0;
          if (pendiente_q == 3'd0) begin
            estado_d = FIN;
          end else begin
            estado_d = MOTOR;
          end
        end else begin
          cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end

      FIN: begin
        estado_d = REPOSO;
      end

      default: begin
        estado_d = REPOSO;
        cnt_d    = '0;
      end
    endcase

    motor_d   = (estado_d == MOTOR);
    ocupado_d = (estado_d == MOTOR) || (estado_d == ESPERA) || (estado_d == PAUSA);
    listo_d   = (estado_d == FIN);
    falla_d   = (estado_d == FALLA);
  end

  assign motor      = motor_q;
  assign ocupado    = ocupado_q;
  assign listo      = listo_q;
  assign falla      = falla_q;
  assign entregados = entregados_q;

endmodule

// File: tb/tb_dispensador_cambio.sv
// Randomized self-checking bench for dispensador_cambio against a per-note timing model.
`timescale 1ns/1ps
module tb_dispensador_cambio;

  localparam int M = 4;
  localparam int T = 16;
  localparam int P = 2;
`ifdef CAMBIO_REINTENTO_EN
  localparam int INTENTOS = 2;
`else
  localparam int INTENTOS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       inicio = 1'b0;
  logic [2:0] vuelto = 3'd0;
  logic       sensor_billete = 1'b0;
  logic       motor, ocupado, listo, falla;
  logic [2:0] entregados;

  int n_checks = 0;
  int n_pass   = 0;

  bit resp [16];
  int dly  [16];

  int m_pulses, m_ent, m_listo_t, m_falla_t;
  int o_pulses, o_bad_len, o_listo_cnt, o_listo_t, o_falla_t, o_both;
  int o_ocup_err, o_ent_err, o_ent, o_motor, o_ocupado, o_stopped;

  dispensador_cambio #(.MOTOR_CICLOS(M), .TIMEOUT(T), .PAUSA_CICLOS(P)) dut (
    .clk            (clk),
    .reset          (reset),
    .inicio         (inicio),
    .vuelto         (vuelto),
    .sensor_billete (sensor_billete),
    .motor          (motor),
    .ocupado        (ocupado),
    .listo          (listo),
    .falla          (falla),
    .entregados     (entregados)
  );

  always #5 clk = ~clk;

  task automatic set_plan(input bit r, input int d);
    for (int i = 0; i < 16; i++) begin
      resp[i] = r;
      dly[i]  = d;
    end
  endtask

  // Per note: motor burst, then either the sensor answers (delay + register + decision) or the timeout expires.
  task automatic model_job(input int v);
    int t, a, tries;
    bit done;
    t = 1; a = 0;
    m_pulses = 0; m_ent = 0; m_listo_t = -1; m_falla_t = -1;
    for (int n = 0; n < v; n++) begin
      tries = 0; done = 1'b0;
      while (!done) begin
        t += M;
        m_pulses++;
        if (resp[a]) begin
          t += dly[a] + 2 + P;
          m_ent++;
          done = 1'b1;
        end else begin
          t += T;
          tries++;
          if (tries >= INTENTOS) begin
            m_falla_t = t;
            return;
          end
          t += P;
        end
        a++;
      end
    end
    m_listo_t = t;
  endtask

  // Starts a job, answers motor bursts with sensor pulses per plan, and records what the DUT did.
  task automatic run_job(input int v, input int inj_at, input int inj_v, input int budget, input int stop_pulse);
    bit prev_motor;
    int run_len, attempt, wait_cnt, sens_left, extra, prev_ent;
    o_pulses = 0; o_bad_len = 0; o_listo_cnt = 0; o_listo_t = -1; o_falla_t = -1;
    o_both = 0; o_ocup_err = 0; o_ent_err = 0; o_stopped = 0;
    prev_motor = 1'b0; run_len = 0; attempt = 0; wait_cnt = -1; sens_left = 0; extra = 0; prev_ent = 0;
    inicio = 1'b1;
    vuelto = 3'(v);
    for (int k = 1; k <= budget && extra < 5 && o_stopped == 0; k++) begin
      @(posedge clk); #1;
      if (k == 1) inicio = 1'b0;
      if (k == inj_at) begin
        inicio = 1'b1;
        vuelto = 3'(inj_v);
      end else if (k == inj_at + 1) begin
        inicio = 1'b0;
      end
      if (motor) run_len++;
      if (motor && !prev_motor) o_pulses++;
      if (!motor && prev_motor) begin
        if (run_len != M) o_bad_len++;
        run_len = 0;
        if (attempt < 16 && resp[attempt]) wait_cnt = dly[attempt];
        attempt++;
      end
      if (motor && !ocupado) o_ocup_err++;
      if (listo) begin
        o_listo_cnt++;
        if (o_listo_t < 0) o_listo_t = k;
        if (ocupado) o_ocup_err++;
        if (falla) o_both++;
      end
      if (falla && o_falla_t < 0) o_falla_t = k;
      if (int'(entregados) < prev_ent || int'(entregados) > prev_ent + 1) o_ent_err++;
      prev_ent = int'(entregados);
      prev_motor = motor;
      if (wait_cnt == 0) begin
        sens_left = 2;
        wait_cnt = -1;
      end else if (wait_cnt > 0) begin
        wait_cnt--;
      end
      sensor_billete = (sens_left > 0);
      if (sens_left > 0) sens_left--;
      if (o_listo_t >= 0 || o_falla_t >= 0) extra++;
      if (stop_pulse > 0 && o_pulses == stop_pulse && motor) o_stopped = 1;
    end
    o_ent = int'(entregados);
    o_motor = int'(motor);
    o_ocupado = int'(ocupado);
    if (o_stopped == 0) sensor_billete = 1'b0;
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (motor !== 1'b0) $display("FAIL reset_motor: got %b expected 0", motor); else n_pass++;
    n_checks++; if (ocupado !== 1'b0) $display("FAIL reset_ocupado: got %b expected 0", ocupado); else n_pass++;
    n_checks++; if (listo !== 1'b0) $display("FAIL reset_listo: got %b expected 0", listo); else n_pass++;
    n_checks++; if (falla !== 1'b0) $display("FAIL reset_falla: got %b expected 0", falla); else n_pass++;
    n_checks++; if (entregados !== 3'd0) $display("FAIL reset_entregados: got %0d expected 0", entregados); else n_pass++;
    #3 reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_three_notes();
    set_plan(1'b1, 2);
    model_job(3);
    run_job(3, -1, 0, 400, 0);
    n_checks++; if (o_pulses != 3) $display("FAIL three_pulses: got %0d expected 3", o_pulses); else n_pass++;
    n_checks++; if (o_bad_len != 0) $display("FAIL three_pulse_len: got %0d bad pulses expected 0", o_bad_len); else n_pass++;
    n_checks++; if (o_ent != 3) $display("FAIL three_entregados: got %0d expected 3", o_ent); else n_pass++;
    n_checks++; if (o_ent_err != 0) $display("FAIL three_steps: got %0d bad steps expected 0", o_ent_err); else n_pass++;
    n_checks++; if (o_listo_cnt != 1) $display("FAIL three_listo_cnt: got %0d expected 1", o_listo_cnt); else n_pass++;
    n_checks++; if (o_listo_t != m_listo_t) $display("FAIL three_listo_time: got %0d expected %0d", o_listo_t, m_listo_t); else n_pass++;
    n_checks++; if (o_ocup_err != 0) $display("FAIL three_ocupado: got %0d errors expected 0", o_ocup_err); else n_pass++;
    n_checks++; if (o_falla_t != -1) $display("FAIL three_falla: got cycle %0d expected none", o_falla_t); else n_pass++;
  endtask

  task automatic test_zero_notes();
    model_job(0);
    run_job(0, -1, 0, 50, 0);
    n_checks++; if (o_listo_t != 1) $display("FAIL zero_listo_time: got %0d expected 1", o_listo_t); else n_pass++;
    n_checks++; if (o_listo_cnt != 1) $display("FAIL zero_listo_cnt: got %0d expected 1", o_listo_cnt); else n_pass++;
    n_checks++; if (o_pulses != 0) $display("FAIL zero_motor: got %0d pulses expected 0", o_pulses); else n_pass++;
    n_checks++; if (o_ocup_err != 0 || o_ocupado != 0) $display("FAIL zero_ocupado: got %0d errors expected 0", o_ocup_err); else n_pass++;
    n_checks++; if (o_ent != 0) $display("FAIL zero_entregados: got %0d expected 0", o_ent); else n_pass++;
  endtask

  task automatic test_jam();
    set_plan(1'b0, 2);
    resp[0] = 1'b1;
    model_job(2);
    run_job(2, -1, 0, 400, 0);
    n_checks++; if (o_falla_t != m_falla_t) $display("FAIL jam_falla_time: got %0d expected %0d", o_falla_t, m_falla_t); else n_pass++;
    n_checks++; if (o_ent != 1) $display("FAIL jam_entregados: got %0d expected 1", o_ent); else n_pass++;
    n_checks++; if (o_listo_cnt != 0) $display("FAIL jam_listo: got %0d pulses expected 0", o_listo_cnt); else n_pass++;
    n_checks++; if (o_motor != 0) $display("FAIL jam_motor: got %0d expected 0", o_motor); else n_pass++;
    n_checks++; if (falla !== 1'b1) $display("FAIL jam_sticky: got %b expected 1", falla); else n_pass++;
    n_checks++; if (o_pulses != m_pulses) $display("FAIL jam_pulses: got %0d expected %0d", o_pulses, m_pulses); else n_pass++;
  endtask

  task automatic test_retry();
    set_plan(1'b1, 2);
    resp[0] = 1'b0;
    model_job(1);
    run_job(1, -1, 0, 200, 0);
    n_checks++; if (o_pulses != m_pulses) $display("FAIL retry_pulses: got %0d expected %0d", o_pulses, m_pulses); else n_pass++;
    n_checks++; if (o_ent != m_ent) $display("FAIL retry_entregados: got %0d expected %0d", o_ent, m_ent); else n_pass++;
    n_checks++; if (o_listo_t != m_listo_t) $display("FAIL retry_listo_time: got %0d expected %0d", o_listo_t, m_listo_t); else n_pass++;
    n_checks++; if (o_falla_t != m_falla_t) $display("FAIL retry_falla_time: got %0d expected %0d", o_falla_t, m_falla_t); else n_pass++;
    set_plan(1'b0, 2);
    model_job(1);
    run_job(1, -1, 0, 200, 0);
    n_checks++; if (o_pulses != m_pulses) $display("FAIL retry2_pulses: got %0d expected %0d", o_pulses, m_pulses); else n_pass++;
    n_checks++; if (o_falla_t != m_falla_t) $display("FAIL retry2_falla_time: got %0d expected %0d", o_falla_t, m_falla_t); else n_pass++;
    n_checks++; if (o_listo_cnt != 0) $display("FAIL retry2_listo: got %0d expected 0", o_listo_cnt); else n_pass++;
  endtask

  task automatic test_ignored_inicio();
    set_plan(1'b1, 1);
    model_job(5);
    run_job(5, 10, 1, 400, 0);
    n_checks++; if (o_ent != 5) $display("FAIL ignored_entregados: got %0d expected 5", o_ent); else n_pass++;
    n_checks++; if (o_pulses != 5) $display("FAIL ignored_pulses: got %0d expected 5", o_pulses); else n_pass++;
    n_checks++; if (o_listo_t != m_listo_t) $display("FAIL ignored_listo_time: got %0d expected %0d", o_listo_t, m_listo_t); else n_pass++;
  endtask

  task automatic test_random_jobs();
    bit last_fail;
    int v;
    last_fail = 1'b1;
    for (int j = 0; j < 12; j++) begin
      v = last_fail ? int'($urandom_range(1, 7)) : int'($urandom_range(0, 7));
      for (int i = 0; i < 16; i++) begin
        resp[i] = ($urandom_range(0, 9) != 0);
        dly[i]  = int'($urandom_range(0, 10));
      end
      model_job(v);
      run_job(v, -1, 0, 600, 0);
      n_checks++; if (o_pulses != m_pulses || o_bad_len != 0) $display("FAIL rnd%0d_pulses: got %0d (bad %0d) expected %0d", j, o_pulses, o_bad_len, m_pulses); else n_pass++;
      n_checks++; if (o_ent != m_ent || o_ent_err != 0) $display("FAIL rnd%0d_entregados: got %0d (bad steps %0d) expected %0d", j, o_ent, o_ent_err, m_ent); else n_pass++;
      n_checks++; if (o_listo_t != m_listo_t || o_listo_cnt != (m_listo_t >= 0 ? 1 : 0)) $display("FAIL rnd%0d_listo: got cycle %0d count %0d expected cycle %0d", j, o_listo_t, o_listo_cnt, m_listo_t); else n_pass++;
      n_checks++; if (o_falla_t != m_falla_t) $display("FAIL rnd%0d_falla: got cycle %0d expected %0d", j, o_falla_t, m_falla_t); else n_pass++;
      n_checks++; if (o_both != 0 || o_ocup_err != 0 || o_ocupado != 0) $display("FAIL rnd%0d_flags: got both %0d ocupado errors %0d expected 0", j, o_both, o_ocup_err); else n_pass++;
      last_fail = (m_falla_t >= 0);
    end
  endtask

  task automatic test_reset_mid_job();
    int bad;
    set_plan(1'b1, 1);
    run_job(3, -1, 0, 300, 2);
    n_checks++; if (o_stopped != 1) $display("FAIL midrst_reach: got %0d expected second motor pulse reached", o_stopped); else n_pass++;
    n_checks++; if (entregados !== 3'd1) $display("FAIL midrst_before: got %0d expected 1", entregados); else n_pass++;
    #3 reset = 1'b1;
    #1;
    n_checks++; if (motor !== 1'b0) $display("FAIL midrst_motor: got %b expected 0", motor); else n_pass++;
    n_checks++; if (ocupado !== 1'b0) $display("FAIL midrst_ocupado: got %b expected 0", ocupado); else n_pass++;
    n_checks++; if (entregados !== 3'd0) $display("FAIL midrst_entregados: got %0d expected 0", entregados); else n_pass++;
    sensor_billete = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    bad = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (listo || motor || ocupado || falla) bad++;
    end
    n_checks++; if (bad != 0) $display("FAIL midrst_after: got %0d active cycles expected 0", bad); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_three_notes();
    test_zero_notes();
    test_jam();
    test_retry();
    test_ignored_inicio();
    test_random_jobs();
    test_reset_mid_job();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
